cfg_mem_arbiter: RTL and testbench

- Shares the single-port 35-bit configuration memory between NREQ requesters: the user control unit (index 0), the time scheduler and the remote link.
- Round-robin arbitration with a fixed 3-cycle access sequence (IDLE, ACCESS, ACK).
- Write-lock protection: while locked, only requester 0 may write.
- Sits between the requesters and the configuration memory unit.

---
 rtl/cfg_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cfg_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_mem_arbiter.sv
// cfg_mem_arbiter
//   Shares the single-port configuration memory between NREQ requesters
//   (index 0 is the user control unit). Each transaction runs a fixed
//   IDLE -> ACCESS -> ACK sequence. Requesters win in round-robin order.
//   While wr_lock is high, only requester 0 may write. A rejected write never
//   strobes the memory and completes with err.
//
// Ports
//   clk, arst          clock (rising edge), synchronous active-high reset
//   req, req_we        per-requester request level and write/read select
//   req_addr           flattened addresses, requester i at [i*AW +: AW]
//   req_wdata          flattened write data, requester i at [i*DW +: DW]
//   wr_lock            1 = only requester 0 may write
//   gnt                one-hot grant, held through ACCESS and ACK
//   ack, err           one-cycle completion pulse and rejection flag
//   rdata              read data, valid with ack, held until the next read
//   mem_en, mem_we     memory strobe and write enable
//   mem_addr/mem_wdata memory address and write data
//   mem_rdata          memory read data, valid while the address is presented
//   dbg_state          00 IDLE, 01 ACCESS, 10 ACK
module cfg_mem_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 35,
  parameter int AW   = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic              wr_lock,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int LW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } state_t;

  state_t          state, state_next;
  logic [LW-1:0]   last;
  logic [LW-1:0]   cur;
  logic [LW-1:0]   winner;
  logic            found;
  logic [LW:0]     pos;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            reject;
  logic            reject_q;
  logic            mem_en_q;

  // Round-robin pick: scan last+1, last+2, ... wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = {1'b0, last} + (LW+1)'(k);
      if (pos >= (LW+1)'(NREQ)) pos = pos - (LW+1)'(NREQ);
      if (!found && req[pos[LW-1:0]]) begin
        found  = 1'b1;
        winner = pos[LW-1:0];
      end
    end
  end

  // Select the winner's fields. A write is rejected if it comes from
  // anyone but requester 0 while the lock is up at grant time.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == LW'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
    reject = sel_we && wr_lock && (winner != '0);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (found) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_ACK;
      ST_ACK:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Datapath. All inputs are captured only at the grant edge, so a granted
  // transaction finishes with its original fields whatever the requester does.
  always_ff @(posedge clk) begin
    if (arst) begin
      gnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_en_q  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      reject_q  <= 1'b0;
      cur       <= '0;
      last      <= LW'(NREQ-1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            cur       <= winner;
            mem_en_q  <= !reject;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            reject_q  <= reject;
          end
        end
        ST_ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we   <= 1'b0;
          ack      <= gnt;
          err      <= reject_q;
          if (!mem_we) rdata <= mem_rdata;
        end
        ST_ACK: begin
          ack  <= '0;
          err  <= 1'b0;
          gnt  <= '0;
          last <= cur;
        end
        default: ;
      endcase
    end
  end

  // The strobe is gated by reset, so a write still pending when reset
  // arrives never reaches the memory on that edge.
  assign mem_en    = mem_en_q & ~arst;
  assign dbg_state = state;

endmodule

// File: tb/tb_cfg_mem_arbiter.sv
// tb_cfg_mem_arbiter
//   Self-checking bench for cfg_mem_arbiter. A behavioural memory sits on the
//   mem_* port. A table of single-requester transactions is applied in a loop.
//   Round-robin, commitment and reset-abort are exercised by hand sequences.
//   Expected completions go into a queue when driven and are popped by a
//   monitor whenever ack fires.
module tb_cfg_mem_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 35;
  localparam int AW   = 4;

  logic              clk = 1'b0;
  logic              arst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic              wr_lock;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic [1:0]        dbg_state;

  cfg_mem_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .arst(arst), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .wr_lock(wr_lock),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural configuration memory: clocked write, read of the presented address.
  logic [DW-1:0] env_mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = env_mem[mem_addr];

  typedef struct {
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
    logic [NREQ-1:0] exp_ack;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            chk_rdata;
  } sb_entry_t;

  vec_t      vecs [12];
  sb_entry_t sb_q [$];
  sb_entry_t mon_e;
  int        checks   = 0;
  int        failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Randomise every requester slot so a wrong mux or a late sample shows up.
  task automatic scrambleInputs();
    for (int i = 0; i < NREQ*AW; i++) req_addr[i]  = 1'($urandom);
    for (int i = 0; i < NREQ*DW; i++) req_wdata[i] = 1'($urandom);
    req_we = NREQ'($urandom);
  endtask

  // Drive one single-requester transaction and follow it through its states.
  task automatic applyStimulus(input vec_t v);
    sb_entry_t e;
    @(negedge clk);
    scrambleInputs();
    req = '0;
    req[v.who] = 1'b1;
    req_we[v.who] = v.we;
    req_addr[v.who*AW +: AW] = v.addr;
    req_wdata[v.who*DW +: DW] = v.wdata;
    wr_lock = v.lock;
    checkOutput("idle_state", 64'(dbg_state), 64'(0));
    e.ack = v.exp_ack;
    e.err = v.exp_err;
    e.rdata = v.exp_rdata;
    e.chk_rdata = !v.we;
    sb_q.push_back(e);
    @(negedge clk);
    checkOutput("access_state", 64'(dbg_state), 64'(1));
    checkOutput("access_gnt", 64'(gnt), 64'(v.exp_ack));
    checkOutput("access_mem_en", 64'(mem_en), 64'(!v.exp_err));
    if (!v.exp_err) begin
      checkOutput("access_mem_we", 64'(mem_we), 64'(v.we));
      checkOutput("access_mem_addr", 64'(mem_addr), 64'(v.addr));
      if (v.we) checkOutput("access_mem_wdata", 64'(mem_wdata), 64'(v.wdata));
    end
    req = '0;
    scrambleInputs();
    wr_lock = ~wr_lock;
    @(negedge clk);
    checkOutput("ack_state", 64'(dbg_state), 64'(2));
    @(negedge clk);
    checkOutput("exit_state", 64'(dbg_state), 64'(0));
    checkOutput("exit_gnt", 64'(gnt), 64'(0));
  endtask

  // Scoreboard monitor plus per-cycle invariants.
  always @(negedge clk) begin
    checkOutput("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
    if (ack == '0) begin
      checkOutput("err_without_ack", 64'(err), 64'(0));
    end else if (sb_q.size() == 0) begin
      checkOutput("unexpected_ack", 64'(ack), 64'(0));
    end else begin
      mon_e = sb_q.pop_front();
      checkOutput("sb_ack", 64'(ack), 64'(mon_e.ack));
      checkOutput("sb_err", 64'(err), 64'(mon_e.err));
      if (mon_e.chk_rdata) checkOutput("sb_rdata", 64'(rdata), 64'(mon_e.rdata));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n_ack;
    int cyc;
    logic [NREQ-1:0] restore;
    sb_entry_t e;

    //            who we    addr   wdata             lock  ack     err   rdata
    vecs[0]  = '{0, 1'b1, 4'h3, 35'h1_2345_6789, 1'b0, 3'b001, 1'b0, 35'h0};
    vecs[1]  = '{1, 1'b0, 4'h3, 35'h0,           1'b0, 3'b010, 1'b0, 35'h1_2345_6789};
    vecs[2]  = '{2, 1'b1, 4'h5, 35'h0_AAAA_5555, 1'b1, 3'b100, 1'b1, 35'h0};
    vecs[3]  = '{2, 1'b0, 4'h5, 35'h0,           1'b1, 3'b100, 1'b0, 35'h0};
    vecs[4]  = '{0, 1'b1, 4'h5, 35'h0_AAAA_5555, 1'b1, 3'b001, 1'b0, 35'h0};
    vecs[5]  = '{1, 1'b0, 4'h5, 35'h0,           1'b1, 3'b010, 1'b0, 35'h0_AAAA_5555};
    vecs[6]  = '{1, 1'b1, 4'h9, 35'h7_FFFF_FFFF, 1'b0, 3'b010, 1'b0, 35'h0};
    vecs[7]  = '{2, 1'b0, 4'h9, 35'h0,           1'b0, 3'b100, 1'b0, 35'h7_FFFF_FFFF};
    vecs[8]  = '{1, 1'b1, 4'h9, 35'h0,           1'b1, 3'b010, 1'b1, 35'h0};
    vecs[9]  = '{0, 1'b0, 4'h9, 35'h0,           1'b1, 3'b001, 1'b0, 35'h7_FFFF_FFFF};
    vecs[10] = '{2, 1'b1, 4'hF, 35'h5_0000_0001, 1'b0, 3'b100, 1'b0, 35'h0};
    vecs[11] = '{0, 1'b0, 4'hF, 35'h0,           1'b0, 3'b001, 1'b0, 35'h5_0000_0001};

    arst = 1'b1;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    wr_lock = 1'b0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_state", 64'(dbg_state), 64'(0));
    checkOutput("rst_gnt", 64'(gnt), 64'(0));
    checkOutput("rst_ack", 64'(ack), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
    checkOutput("rst_rdata", 64'(rdata), 64'(0));
    checkOutput("rst_mem_en", 64'(mem_en), 64'(0));
    checkOutput("rst_mem_we", 64'(mem_we), 64'(0));
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'(0));

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    checkOutput("mem3", 64'(env_mem[3]), 64'(35'h1_2345_6789));
    checkOutput("mem5", 64'(env_mem[5]), 64'(35'h0_AAAA_5555));
    checkOutput("mem9", 64'(env_mem[9]), 64'(35'h7_FFFF_FFFF));

    // Round-robin from a fresh pointer: all three read continuously,
    // each dropping for one cycle after its ack.
    $display("[TB] round-robin");
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    req_we = '0;
    req_addr = {4'h9, 4'h5, 4'h3};
    wr_lock = 1'b0;
    e = '{3'b001, 1'b0, 35'h1_2345_6789, 1'b1}; sb_q.push_back(e);
    e = '{3'b010, 1'b0, 35'h0_AAAA_5555, 1'b1}; sb_q.push_back(e);
    e = '{3'b100, 1'b0, 35'h7_FFFF_FFFF, 1'b1}; sb_q.push_back(e);
    e = '{3'b001, 1'b0, 35'h1_2345_6789, 1'b1}; sb_q.push_back(e);
    req = 3'b111;
    restore = '0;
    n_ack = 0;
    cyc = 0;
    while (n_ack < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req = req | restore;
      restore = '0;
      if (ack != '0) begin
        n_ack++;
        req = req & ~ack;
        restore = ack;
      end
    end
    req = '0;
    checkOutput("rr_ack_count", 64'(n_ack), 64'(4));
    repeat (3) @(negedge clk);
    checkOutput("rr_idle", 64'(dbg_state), 64'(0));

    // Reset during ACCESS aborts a write; afterwards requester 0 wins first.
    $display("[TB] reset abort");
    @(negedge clk);
    req = 3'b001;
    req_we = 3'b001;
    req_addr[0 +: AW] = 4'h7;
    req_wdata[0 +: DW] = 35'h0_DEAD_BEEF;
    @(negedge clk);
    checkOutput("abort_access", 64'(dbg_state), 64'(1));
    checkOutput("abort_mem_en", 64'(mem_en), 64'(1));
    arst = 1'b1;
    req = '0;
    @(negedge clk);
    arst = 1'b0;
    checkOutput("abort_state", 64'(dbg_state), 64'(0));
    checkOutput("abort_gnt", 64'(gnt), 64'(0));
    checkOutput("abort_ack", 64'(ack), 64'(0));
    checkOutput("abort_mem_en_after", 64'(mem_en), 64'(0));
    @(negedge clk);
    checkOutput("abort_mem7", 64'(env_mem[7]), 64'(0));
    e = '{3'b001, 1'b0, 35'h5_0000_0001, 1'b1}; sb_q.push_back(e);
    e = '{3'b010, 1'b0, 35'h1_2345_6789, 1'b1}; sb_q.push_back(e);
    req_we = '0;
    req_addr = {4'h0, 4'h3, 4'hF};
    req = 3'b011;
    @(negedge clk);
    checkOutput("post_rst_gnt", 64'(gnt), 64'(3'b001));
    req = 3'b010;
    cyc = 0;
    while (ack != 3'b010 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    req = '0;
    checkOutput("post_rst_second", 64'(ack), 64'(3'b010));
    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
